// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment codes
// (gfedcba, bit0 = a) and the supported digit-count range.
package ssd_pkg;

  typedef logic [6:0] seg_t;

  localparam int NUM_DIGITS_MIN = 1;
  localparam int NUM_DIGITS_MAX = 8;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  function automatic seg_t seg_lookup(input logic [3:0] nib);
    case (nib)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/ssd_if.sv
// Host-side load bus plus the pin-side segment/anode outputs of the scan driver.
interface ssd_if #(parameter int NUM_DIGITS = 4);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    hex_mode;
  logic                    blank_lz;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    pending;

  modport master (output load, value, dp_in, hex_mode, blank_lz,
                  input  seg, dp, an, pending);
  modport slave  (input  load, value, dp_in, hex_mode, blank_lz,
                  output seg, dp, an, pending);
endinterface

// File: rtl/ssd_hex_decode.sv
// Combinational nibble-to-segment decoder, active-low output.
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  output seg_t       seg
);

  always_comb begin
    if (blank || (!hex_mode && nibble > 4'd9))
      seg = SEG_BLANK;
    else
      seg = seg_lookup(nibble);
  end

endmodule

// File: rtl/ssd_scan.sv
// Multiplexed seven-segment driver: frame-synchronous value update, BCD/hex
// decode, leading-zero blanking and registered pin outputs.
module ssd_scan
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input logic   clk,
  input logic   rst,
  ssd_if.slave  bus
);

  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW  = $clog2(REFRESH_DIV);
  localparam bit INV = ~ACTIVE_LOW;

  if (NUM_DIGITS < NUM_DIGITS_MIN || NUM_DIGITS > NUM_DIGITS_MAX) begin : g_bad_digits
    $error("ssd_scan: NUM_DIGITS out of range");
  end

  logic [PW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    tick, frame_end;
  logic [4*NUM_DIGITS-1:0] p_value, d_value;
  logic [NUM_DIGITS-1:0]   p_dp, d_dp;
  logic                    p_hex, p_blz, d_hex, d_blz, pending_q;
  logic [3:0]              nib;
  logic                    dp_sel, lz_sel, zero_run;
  logic [NUM_DIGITS-1:0]   an_act;
  seg_t                    seg_l;
  seg_t                    seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;

  assign tick      = (cnt == PW'(REFRESH_DIV - 1));
  assign frame_end = tick && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + PW'(1);
      if (tick)
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end
  end

  // A load landing on frame_end bypasses the pending stage entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_value   <= '0;
      p_dp      <= '0;
      p_hex     <= 1'b0;
      p_blz     <= 1'b0;
      d_value   <= '0;
      d_dp      <= '0;
      d_hex     <= 1'b0;
      d_blz     <= 1'b0;
      pending_q <= 1'b0;
    end else if (bus.load && frame_end) begin
      d_value   <= bus.value;
      d_dp      <= bus.dp_in;
      d_hex     <= bus.hex_mode;
      d_blz     <= bus.blank_lz;
      pending_q <= 1'b0;
    end else if (bus.load) begin
      p_value   <= bus.value;
      p_dp      <= bus.dp_in;
      p_hex     <= bus.hex_mode;
      p_blz     <= bus.blank_lz;
      pending_q <= 1'b1;
    end else if (frame_end && pending_q) begin
      d_value   <= p_value;
      d_dp      <= p_dp;
      d_hex     <= p_hex;
      d_blz     <= p_blz;
      pending_q <= 1'b0;
    end
  end

  // Walk from the most significant digit down so zero_run tracks "all zero from here up".
  always_comb begin
    nib      = 4'd0;
    dp_sel   = 1'b0;
    lz_sel   = 1'b0;
    an_act   = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (d_value[4*i +: 4] == 4'd0);
      if (idx == IW'(i)) begin
        nib       = d_value[4*i +: 4];
        dp_sel    = d_dp[i];
        lz_sel    = d_blz && zero_run && (i != 0);
        an_act[i] = 1'b1;
      end
    end
  end

  ssd_hex_decode u_dec (
    .nibble   (nib),
    .hex_mode (d_hex),
    .blank    (lz_sel),
    .seg      (seg_l)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
      dp_q  <= ACTIVE_LOW;
      an_q  <= {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      seg_q <= seg_l ^ {7{INV}};
      dp_q  <= ~dp_sel ^ INV;
      an_q  <= ~an_act ^ {NUM_DIGITS{INV}};
    end
  end

  assign bus.seg     = seg_q;
  assign bus.dp      = dp_q;
  assign bus.an      = an_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_ssd_scan.sv
// Bench for ssd_scan: 4-digit active-low instance and 1-digit active-high
// instance driven side by side against a cycle-count arithmetic model.
module tb_ssd_scan;

  localparam int N0 = 4, R0 = 4;
  localparam int N1 = 1, R1 = 3;

  localparam logic [6:0] SEG_REF [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        hex = 1'b0;
  logic        blz = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ssd_if #(.NUM_DIGITS(N0)) bus0 ();
  ssd_if #(.NUM_DIGITS(N1)) bus1 ();

  assign bus0.load     = load;
  assign bus0.value    = value;
  assign bus0.dp_in    = dp_in;
  assign bus0.hex_mode = hex;
  assign bus0.blank_lz = blz;
  assign bus1.load     = load;
  assign bus1.value    = value[3:0];
  assign bus1.dp_in    = dp_in[0];
  assign bus1.hex_mode = hex;
  assign bus1.blank_lz = blz;

  ssd_scan #(.NUM_DIGITS(N0), .REFRESH_DIV(R0), .ACTIVE_LOW(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  ssd_scan #(.NUM_DIGITS(N1), .REFRESH_DIV(R1), .ACTIVE_LOW(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  // Model state, one slot per instance; k counts clock edges since reset released.
  int          k [2];
  bit          m_pend [2];
  logic [15:0] dv [2], pv [2];
  logic [3:0]  ddp [2], pdp [2];
  bit          dhex [2], phex [2], dblz [2], pblz [2];
  logic [6:0]  e_seg [2];
  bit          e_dp [2];
  logic [3:0]  e_an [2];
  bit          e_pend [2];

  typedef struct packed {
    logic [15:0]     value;
    logic            hex;
    logic            blz;
    logic [3:0][6:0] seg;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(logic [15:0] v, logic h, logic b,
                              logic [6:0] s3, logic [6:0] s2, logic [6:0] s1, logic [6:0] s0);
    vec_t r;
    r.value = v; r.hex = h; r.blz = b;
    r.seg[3] = s3; r.seg[2] = s2; r.seg[1] = s1; r.seg[0] = s0;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg_low(logic [15:0] v, bit h, bit b, int i);
    int nib;
    nib = int'((v >> (4*i)) & 16'hF);
    if (i > 0 && b && (v >> (4*i)) == 16'd0) return 7'h7F;
    if (nib > 9 && !h) return 7'h7F;
    return SEG_REF[nib];
  endfunction

  task automatic model_edge(int j, int n, int r, bit al, logic [15:0] v, logic [3:0] dpv);
    logic [3:0] amask, onehot;
    logic [6:0] s;
    int idx;
    bit fe;
    amask = 4'((1 << n) - 1);
    if (rst) begin
      k[j] = 0; m_pend[j] = 0;
      dv[j] = '0; pv[j] = '0; ddp[j] = '0; pdp[j] = '0;
      dhex[j] = 0; phex[j] = 0; dblz[j] = 0; pblz[j] = 0;
      e_seg[j] = al ? 7'h7F : 7'h00;
      e_dp[j]  = al;
      e_an[j]  = al ? amask : 4'h0;
    end else begin
      idx = (k[j] / r) % n;
      fe  = (k[j] % (n*r)) == (n*r - 1);
      s   = exp_seg_low(dv[j], dhex[j], dblz[j], idx);
      onehot   = 4'(1 << idx);
      e_seg[j] = al ? s : ~s;
      e_dp[j]  = al ? !ddp[j][idx] : ddp[j][idx];
      e_an[j]  = al ? (~onehot & amask) : onehot;
      if (load && fe) begin
        dv[j] = v; ddp[j] = dpv; dhex[j] = hex; dblz[j] = blz; m_pend[j] = 0;
      end else if (load) begin
        pv[j] = v; pdp[j] = dpv; phex[j] = hex; pblz[j] = blz; m_pend[j] = 1;
      end else if (fe && m_pend[j]) begin
        dv[j] = pv[j]; ddp[j] = pdp[j]; dhex[j] = phex[j]; dblz[j] = pblz[j]; m_pend[j] = 0;
      end
      k[j]++;
    end
    e_pend[j] = m_pend[j];
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, N0, R0, 1'b1, value, dp_in);
    model_edge(1, N1, R1, 1'b0, value & 16'h000F, dp_in & 4'h1);
    @(negedge clk);
    chk("seg0", 16'(bus0.seg), 16'(e_seg[0]));
    chk("dp0",  16'(bus0.dp),  16'(e_dp[0]));
    chk("an0",  16'(bus0.an),  16'(e_an[0]));
    chk("pend0", 16'(bus0.pending), 16'(e_pend[0]));
    chk("seg1", 16'(bus1.seg), 16'(e_seg[1]));
    chk("dp1",  16'(bus1.dp),  16'(e_dp[1]));
    chk("an1",  16'(bus1.an),  16'(e_an[1]));
    chk("pend1", 16'(bus1.pending), 16'(e_pend[1]));
  endtask

  task automatic load_val(logic [15:0] v, logic h, logic b);
    value = v; hex = h; blz = b; dp_in = 4'($urandom);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic align(int pos);
    for (int g = 0; g < 64 && (k[0] % (N0*R0)) != pos; g++) step();
  endtask

  initial begin
    bit saw_one;

    tbl[0] = mk(16'h1234, 0, 0, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);
    tbl[1] = mk(16'h00AF, 1, 0, 7'b1000000, 7'b1000000, 7'b0001000, 7'b0001110);
    tbl[2] = mk(16'h00AF, 0, 0, 7'b1000000, 7'b1000000, 7'b1111111, 7'b1111111);
    tbl[3] = mk(16'h0005, 0, 1, 7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010);
    tbl[4] = mk(16'h0000, 0, 1, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000);
    tbl[5] = mk(16'h00AF, 1, 1, 7'b1111111, 7'b1111111, 7'b0001000, 7'b0001110);
    tbl[6] = mk(16'h8070, 0, 1, 7'b0000000, 7'b1000000, 7'b1111000, 7'b1000000);
    tbl[7] = mk(16'hCB96, 1, 0, 7'b1000110, 7'b0000011, 7'b0010000, 7'b0000010);
    tbl[8] = mk(16'hE0D0, 1, 1, 7'b0000110, 7'b1000000, 7'b0100001, 7'b1000000);

    // Reset hold, then the anode walk after release.
    rst = 1'b1;
    repeat (3) begin
      step();
      chk("rst_seg", 16'(bus0.seg), 16'h7F);
      chk("rst_dp",  16'(bus0.dp),  16'h1);
      chk("rst_an",  16'(bus0.an),  16'hF);
    end
    rst = 1'b0;
    for (int c = 0; c < N0*R0; c++) begin
      step();
      chk("an_walk", 16'(bus0.an), 16'(4'(~(4'b0001 << (c / R0)))));
    end

    // Table vectors: load, let it reach the display, then check each digit for a frame.
    for (int t = 0; t < 9; t++) begin
      align(5);
      load_val(tbl[t].value, tbl[t].hex, tbl[t].blz);
      chk("load_pending", 16'(bus0.pending), 16'h1);
      repeat (N0*R0 + 2) step();
      for (int c = 0; c < N0*R0; c++) begin
        step();
        for (int i = 0; i < N0; i++)
          if (bus0.an[i] == 1'b0)
            chk($sformatf("table%0d_digit%0d", t, i), 16'(bus0.seg), 16'(tbl[t].seg[i]));
      end
    end

    // Load coincident with frame_end goes straight to the display.
    align(N0*R0 - 1);
    load_val(16'h5678, 0, 0);
    chk("bypass_pending", 16'(bus0.pending), 16'h0);
    step();
    chk("bypass_an", 16'(bus0.an), 16'hE);
    chk("bypass_seg", 16'(bus0.seg), 16'(7'b0000000));

    // Two loads within one frame: the second one wins.
    align(1);
    load_val(16'h1111, 0, 0);
    chk("ovw_pending", 16'(bus0.pending), 16'h1);
    step();
    load_val(16'h2222, 0, 0);
    saw_one = 1'b0;
    repeat (40) begin
      step();
      if (bus0.seg == 7'b1111001) saw_one = 1'b1;
    end
    chk("ovw_no_1111", 16'(saw_one), 16'h0);
    chk("ovw_2222", 16'(bus0.seg), 16'(7'b0100100));

    // Reset while a value is pending discards it.
    align(1);
    load_val(16'h9999, 0, 0);
    chk("rstmid_pending", 16'(bus0.pending), 16'h1);
    rst = 1'b1;
    step();
    chk("rstmid_seg", 16'(bus0.seg), 16'h7F);
    chk("rstmid_an",  16'(bus0.an),  16'hF);
    chk("rstmid_seg1", 16'(bus1.seg), 16'h00);
    rst = 1'b0;
    step();
    chk("rstmid_pend_after", 16'(bus0.pending), 16'h0);
    chk("rstmid_zero", 16'(bus0.seg), 16'(7'b1000000));
    chk("rstmid_an_after", 16'(bus0.an), 16'hE);
    chk("single_an_active", 16'(bus1.an), 16'h1);

    // Random traffic against the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [15:0] mask;
      case ($urandom_range(0, 3))
        0: mask = 16'h000F;
        1: mask = 16'h00FF;
        2: mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      rst   = ($urandom_range(0, 299) == 0);
      load  = !rst && ($urandom_range(0, 11) == 0);
      value = 16'($urandom) & mask;
      dp_in = 4'($urandom);
      hex   = 1'($urandom);
      blz   = 1'($urandom);
      step();
    end
    rst = 1'b0;
    load = 1'b0;
    repeat (2*N0*R0) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
